// File: rtl/forward_stage_ctrl_pkg.sv
// Shared pipeline definitions: operand forwarding codes and ID/EX control FSM encodings.
// No logic here; latency and backpressure are defined by the modules that import it.
package forward_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_STALLED = 1'b1
  } ctrl_state_e;

  localparam logic [15:0] STALL_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/forward_stage_ctrl_if.sv
// ID->EX stage bundle: hazard controls, forwarding sources, ID attributes and ID/EX register outputs.
// Master drives the ID-side inputs; slave (the stage controller) drives enables and the ID/EX register.
interface forward_stage_ctrl_if
  import forward_stage_ctrl_pkg::*;
#(
  parameter int WORD_W = 16
);
  logic              Stall;
  logic              Flush;
  fwd_sel_e          Forward_Rs;
  fwd_sel_e          Forward_Rt;
  logic [WORD_W-1:0] RF_Rs_Data;
  logic [WORD_W-1:0] RF_Rt_Data;
  logic [WORD_W-1:0] EX_Result;
  logic [WORD_W-1:0] MEM_Result;
  logic [WORD_W-1:0] WB_Result;
  logic              ID_Valid;
  logic              ID_RegWrite;
  logic              ID_IsLWD;
  logic [1:0]        ID_RFWriteAddress;

  logic              PCWrite;
  logic              IFIDWrite;
  logic [WORD_W-1:0] ID_EX_Rs_Data;
  logic [WORD_W-1:0] ID_EX_Rt_Data;
  logic              ID_EX_Valid;
  logic              ID_EX_RegWrite;
  logic              ID_EX_IsLWD;
  logic [1:0]        ID_EX_RFWriteAddress;
  logic [15:0]       StallCount;
  logic              StallError;

  modport master (
    output Stall, Flush, Forward_Rs, Forward_Rt, RF_Rs_Data, RF_Rt_Data,
           EX_Result, MEM_Result, WB_Result, ID_Valid, ID_RegWrite, ID_IsLWD,
           ID_RFWriteAddress,
    input  PCWrite, IFIDWrite, ID_EX_Rs_Data, ID_EX_Rt_Data, ID_EX_Valid,
           ID_EX_RegWrite, ID_EX_IsLWD, ID_EX_RFWriteAddress, StallCount, StallError
  );

  modport slave (
    input  Stall, Flush, Forward_Rs, Forward_Rt, RF_Rs_Data, RF_Rt_Data,
           EX_Result, MEM_Result, WB_Result, ID_Valid, ID_RegWrite, ID_IsLWD,
           ID_RFWriteAddress,
    output PCWrite, IFIDWrite, ID_EX_Rs_Data, ID_EX_Rt_Data, ID_EX_Valid,
           ID_EX_RegWrite, ID_EX_IsLWD, ID_EX_RFWriteAddress, StallCount, StallError
  );
endinterface

// File: rtl/forward_stage_ctrl_operand_mux.sv
// 4:1 operand source selector (RF / EX / MEM / WB), purely combinational.
// Zero latency; no flow control of its own.
module operand_mux
  import forward_stage_ctrl_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  fwd_sel_e          sel,
  input  logic [WORD_W-1:0] rf_dat,
  input  logic [WORD_W-1:0] ex_dat,
  input  logic [WORD_W-1:0] mem_dat,
  input  logic [WORD_W-1:0] wb_dat,
  output logic [WORD_W-1:0] out_dat
);

  always_comb begin
    out_dat = rf_dat;
    case (sel)
      FWD_RF:  out_dat = rf_dat;
      FWD_EX:  out_dat = ex_dat;
      FWD_MEM: out_dat = mem_dat;
      FWD_WB:  out_dat = wb_dat;
      default: out_dat = rf_dat;
    endcase
  end

endmodule

// File: rtl/forward_stage_ctrl.sv
// ID/EX stage controller: forwards operands into the ID/EX register, inserts bubbles on stall/flush.
// Latency 1 cycle; Stall deasserts PCWrite/IFIDWrite in the same cycle, Flush overrides Stall.
module forward_stage_ctrl
  import forward_stage_ctrl_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  forward_stage_ctrl_if.slave bus
);

  ctrl_state_e       state;
  ctrl_state_e       state_nxt;
  logic              stall_eff;
  logic              set_err;
  logic              bubble;
  logic [WORD_W-1:0] rs_sel;
  logic [WORD_W-1:0] rt_sel;

  logic [WORD_W-1:0] rs_q;
  logic [WORD_W-1:0] rt_q;
  logic              valid_q;
  logic              regwrite_q;
  logic              islwd_q;
  logic [1:0]        waddr_q;
  logic [15:0]       stall_cnt_q;
  logic              stall_err_q;

  operand_mux #(.WORD_W(WORD_W)) u_rs_mux (
    .sel     (bus.Forward_Rs),
    .rf_dat  (bus.RF_Rs_Data),
    .ex_dat  (bus.EX_Result),
    .mem_dat (bus.MEM_Result),
    .wb_dat  (bus.WB_Result),
    .out_dat (rs_sel)
  );

  operand_mux #(.WORD_W(WORD_W)) u_rt_mux (
    .sel     (bus.Forward_Rt),
    .rf_dat  (bus.RF_Rt_Data),
    .ex_dat  (bus.EX_Result),
    .mem_dat (bus.MEM_Result),
    .wb_dat  (bus.WB_Result),
    .out_dat (rt_sel)
  );

  // A flush wins over a simultaneous stall, so only an unflushed stall counts as one.
  assign stall_eff = bus.Stall & ~bus.Flush;
  assign bubble    = bus.Flush | bus.Stall | ~bus.ID_Valid;

  assign bus.PCWrite   = ~reset & (bus.Flush | ~bus.Stall);
  assign bus.IFIDWrite = ~reset & (bus.Flush | ~bus.Stall);

  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    case (state)
      ST_RUN: begin
        if (stall_eff) state_nxt = ST_STALLED;
      end
      ST_STALLED: begin
        if (stall_eff) set_err = 1'b1;
        else           state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Bubbles clear only the attributes; operand data and destination hold their last values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_q       <= '0;
      rt_q       <= '0;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      islwd_q    <= 1'b0;
      waddr_q    <= 2'b00;
    end else if (bubble) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      islwd_q    <= 1'b0;
    end else begin
      rs_q       <= rs_sel;
      rt_q       <= rt_sel;
      valid_q    <= 1'b1;
      regwrite_q <= bus.ID_RegWrite;
      islwd_q    <= bus.ID_IsLWD;
      waddr_q    <= bus.ID_RFWriteAddress;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'h0000;
      stall_err_q <= 1'b0;
    end else begin
      if (stall_eff && (stall_cnt_q != STALL_COUNT_MAX)) stall_cnt_q <= stall_cnt_q + 16'h0001;
      if (set_err) stall_err_q <= 1'b1;
    end
  end

  assign bus.ID_EX_Rs_Data        = rs_q;
  assign bus.ID_EX_Rt_Data        = rt_q;
  assign bus.ID_EX_Valid          = valid_q;
  assign bus.ID_EX_RegWrite       = regwrite_q;
  assign bus.ID_EX_IsLWD          = islwd_q;
  assign bus.ID_EX_RFWriteAddress = waddr_q;
  assign bus.StallCount           = stall_cnt_q;
  assign bus.StallError           = stall_err_q;

endmodule
